// File: rtl/flac_enc_pkg.sv
// Shared definitions for the FLAC encoder fixed-predictor blocks.
// Holds the order count, warm-up length, residual width, the order type
// and the state enum of the fixed-order selector.
package flac_enc_pkg;

   localparam int NUM_FIXED_ORDERS = 5;
   localparam int FIXED_WARMUP     = 4;
   localparam int RESIDUAL_W       = 16;

   // Fixed predictor order, 0..4
   typedef logic [2:0] orderT;

   // Selector control states
   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      COMPARE,
      DONE
   } selStateT;

   // Magnitude of a signed residual, one bit wider so that the most
   // negative input (-32768) maps to +32768 without overflow
   function automatic logic [RESIDUAL_W:0] absResidual(input logic signed [RESIDUAL_W-1:0] x);
      logic [RESIDUAL_W:0] ext;
      ext = {x[RESIDUAL_W-1], x};
      return ext[RESIDUAL_W] ? ((~ext) + (RESIDUAL_W+1)'(1)) : ext;
   endfunction

endpackage

// File: rtl/fixed_order_selector_abs_accumulator.sv
// Absolute-value accumulator for one fixed predictor order.
// Sums |iResidual| into an ACC_W-bit register while iEnable is high.
// Build option FIXED_SEL_SATURATE_EN: when defined the sum clamps at
// all-ones and stays there; otherwise it wraps modulo 2^ACC_W.
module abs_accumulator
   import flac_enc_pkg::*;
#(
   parameter int ACC_W = 32
) (
   input  logic                         iClock,
   input  logic                         iReset,
   input  logic                         iClear,
   input  logic                         iEnable,
   input  logic signed [RESIDUAL_W-1:0] iResidual,
   output logic [ACC_W-1:0]             oSum
);

   logic [RESIDUAL_W:0] magnitude;
   logic [ACC_W-1:0]    nextSum;

   assign magnitude = absResidual(iResidual);

`ifdef FIXED_SEL_SATURATE_EN
   // One guard bit above the accumulator catches the carry out; once it
   // is seen the sum is pinned to the largest representable value
   logic [ACC_W:0] wideSum;

   assign wideSum = {1'b0, oSum} + (ACC_W+1)'(magnitude);
   assign nextSum = wideSum[ACC_W] ? {ACC_W{1'b1}} : wideSum[ACC_W-1:0];
`else
   // Plain modular addition; overflow simply wraps around
   assign nextSum = oSum + ACC_W'(magnitude);
`endif

   // Sum register: reset and clear both zero it, clear wins over enable
   always_ff @(posedge iClock) begin
      if (iReset || iClear) begin
         oSum <= '0;
      end else if (iEnable) begin
         oSum <= nextSum;
      end
   end

endmodule

// File: rtl/fixed_order_selector.sv
// Fixed-order selector: accumulates |residual| for the five fixed FLAC
// predictors over a block, skips the warm-up samples, then walks the
// five sums one per cycle and reports the order with the smallest sum
// (lowest order wins ties).
// Build option FIXED_SEL_SATURATE_EN selects saturating accumulators.
module fixed_order_selector
   import flac_enc_pkg::*;
#(
   parameter int BLOCK_SIZE = 4096,
   parameter int ACC_W      = 32
) (
   input  logic                         iClock,
   input  logic                         iReset,
   input  logic                         iEnable,
   input  logic                         iStart,
   input  logic signed [RESIDUAL_W-1:0] iResidual0,
   input  logic signed [RESIDUAL_W-1:0] iResidual1,
   input  logic signed [RESIDUAL_W-1:0] iResidual2,
   input  logic signed [RESIDUAL_W-1:0] iResidual3,
   input  logic signed [RESIDUAL_W-1:0] iResidual4,
   output logic [2:0]                   oBestOrder,
   output logic [ACC_W-1:0]             oBestSum,
   output logic                         oValid,
   output logic                         oBusy
);

   // Sample counter is wide enough for the largest legal block
   localparam int CNT_W = 16;
   localparam logic [CNT_W-1:0] LAST_INDEX   = CNT_W'(BLOCK_SIZE - 1);
   localparam logic [CNT_W-1:0] WARMUP_COUNT = CNT_W'(FIXED_WARMUP);
   localparam orderT            LAST_ORDER   = orderT'(NUM_FIXED_ORDERS - 1);

   selStateT state;
   selStateT nextState;

   // Index of the sample currently presented while in ACCUM
   logic [CNT_W-1:0] sampleCount;

   // Order being examined during COMPARE
   orderT compareIndex;

   // Running best candidate built up during COMPARE
   orderT      candOrder;
   logic [ACC_W-1:0] candSum;

   // Control strobes decoded from the state
   logic startBlock;
   logic advanceCount;
   logic accumulate;
   logic compareStep;
   logic publish;

   logic signed [RESIDUAL_W-1:0] residual [NUM_FIXED_ORDERS];
   logic [ACC_W-1:0]             accSum   [NUM_FIXED_ORDERS];
   logic [ACC_W-1:0]             examinedSum;

   assign residual[0] = iResidual0;
   assign residual[1] = iResidual1;
   assign residual[2] = iResidual2;
   assign residual[3] = iResidual3;
   assign residual[4] = iResidual4;

   // One accumulator per predictor order, all sharing clear and enable
   for (genvar k = 0; k < NUM_FIXED_ORDERS; k++) begin : gAcc
      abs_accumulator #(
         .ACC_W(ACC_W)
      ) uAcc (
         .iClock   (iClock),
         .iReset   (iReset),
         .iClear   (startBlock),
         .iEnable  (accumulate),
         .iResidual(residual[k]),
         .oSum     (accSum[k])
      );
   end

   // State register
   always_ff @(posedge iClock) begin
      if (iReset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic; a start in ACCUM restarts the block in place
   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (iEnable && iStart) begin
               nextState = ACCUM;
            end
         end
         ACCUM: begin
            if (iEnable && !iStart && (sampleCount == LAST_INDEX)) begin
               nextState = COMPARE;
            end
         end
         COMPARE: begin
            if (compareIndex == LAST_ORDER) begin
               nextState = DONE;
            end
         end
         DONE: begin
            nextState = IDLE;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // Output and strobe decode; inputs are only honoured in IDLE and ACCUM
   always_comb begin
      oBusy        = 1'b0;
      startBlock   = 1'b0;
      advanceCount = 1'b0;
      accumulate   = 1'b0;
      compareStep  = 1'b0;
      publish      = 1'b0;
      case (state)
         IDLE: begin
            startBlock = iEnable && iStart;
         end
         ACCUM: begin
            oBusy        = 1'b1;
            startBlock   = iEnable && iStart;
            advanceCount = iEnable && !iStart;
            accumulate   = iEnable && !iStart && (sampleCount >= WARMUP_COUNT);
         end
         COMPARE: begin
            oBusy       = 1'b1;
            compareStep = 1'b1;
         end
         DONE: begin
            publish = 1'b1;
         end
         default: begin
            oBusy = 1'b0;
         end
      endcase
   end

   // Sample counter: index 0 is consumed by the start, so it restarts at 1
   always_ff @(posedge iClock) begin
      if (iReset) begin
         sampleCount <= '0;
      end else if (startBlock) begin
         sampleCount <= CNT_W'(1);
      end else if (advanceCount) begin
         sampleCount <= sampleCount + CNT_W'(1);
      end
   end

   // Compare walker: steps through orders 0..4, parked at 0 otherwise
   always_ff @(posedge iClock) begin
      if (iReset) begin
         compareIndex <= '0;
      end else if (compareStep) begin
         compareIndex <= compareIndex + orderT'(1);
      end else begin
         compareIndex <= '0;
      end
   end

   // Select the accumulator for the order under examination
   always_comb begin
      examinedSum = accSum[0];
      case (compareIndex)
         3'd1:    examinedSum = accSum[1];
         3'd2:    examinedSum = accSum[2];
         3'd3:    examinedSum = accSum[3];
         3'd4:    examinedSum = accSum[4];
         default: examinedSum = accSum[0];
      endcase
   end

   // Candidate tracking: order 0 seeds it, later orders replace it only
   // when strictly smaller, which leaves ties with the lower order
   always_ff @(posedge iClock) begin
      if (iReset) begin
         candOrder <= '0;
         candSum   <= '0;
      end else if (compareStep) begin
         if ((compareIndex == '0) || (examinedSum < candSum)) begin
            candOrder <= compareIndex;
            candSum   <= examinedSum;
         end
      end
   end

   // Result registers: loaded from the final candidate while in DONE and
   // held until the next block completes; oValid is the registered pulse
   always_ff @(posedge iClock) begin
      if (iReset) begin
         oBestOrder <= '0;
         oBestSum   <= '0;
         oValid     <= 1'b0;
      end else begin
         oValid <= publish;
         if (publish) begin
            oBestOrder <= candOrder;
            oBestSum   <= candSum;
         end
      end
   end

endmodule

// File: tb/tb_fixed_order_selector.sv
// Self-checking bench for fixed_order_selector with a 16-sample block.
// Directed vectors come from a table; random blocks are checked against
// a reference model that sums magnitudes over each block directly.
module tb_fixed_order_selector;

   localparam int BS     = 16;
   localparam int WARMUP = 4;
   localparam int NORD   = 5;

   logic               iClock = 1'b0;
   logic               iReset;
   logic               iEnable;
   logic               iStart;
   logic signed [15:0] res [NORD];
   logic [2:0]         oBestOrder;
   logic [31:0]        oBestSum;
   logic               oValid;
   logic               oBusy;

   int checks   = 0;
   int failures = 0;
   int stray    = 0;
   bit allowValid = 1'b0;

   logic signed [15:0] blk [NORD][BS];

   typedef struct {
      int     warm [NORD];
      int     body [NORD];
      int     expOrder;
      longint expSum;
   } vecT;

   vecT vectors [4];

   fixed_order_selector #(
      .BLOCK_SIZE(BS),
      .ACC_W     (32)
   ) dut (
      .iClock    (iClock),
      .iReset    (iReset),
      .iEnable   (iEnable),
      .iStart    (iStart),
      .iResidual0(res[0]),
      .iResidual1(res[1]),
      .iResidual2(res[2]),
      .iResidual3(res[3]),
      .iResidual4(res[4]),
      .oBestOrder(oBestOrder),
      .oBestSum  (oBestSum),
      .oValid    (oValid),
      .oBusy     (oBusy)
   );

   // Free-running clock
   always #5 iClock = ~iClock;

   // Hard stop in case something wedges
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic signed [15:0] randResidual();
      logic signed [15:0] t;
      t = 16'($urandom);
      t = t >>> $urandom_range(0, 15);
      return t;
   endfunction

   // Best order and sum computed straight from the block contents
   function automatic void referenceModel(output int bestOrder, output longint bestSum);
      longint sums [NORD];
      longint v;
      for (int k = 0; k < NORD; k++) begin
         sums[k] = 0;
         for (int i = WARMUP; i < BS; i++) begin
            v = longint'(blk[k][i]);
            sums[k] += (v < 0) ? -v : v;
         end
         sums[k] = sums[k] % (64'd1 << 32);
      end
      bestOrder = 0;
      bestSum   = sums[0];
      for (int k = 1; k < NORD; k++) begin
         if (sums[k] < bestSum) begin
            bestOrder = k;
            bestSum   = sums[k];
         end
      end
   endfunction

   task automatic tick();
      @(posedge iClock);
      #1;
      if (oValid && !allowValid) stray++;
   endtask

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input bit en, input bit st, input bit useBlk, input int idx);
      iEnable = en;
      iStart  = st;
      for (int k = 0; k < NORD; k++) begin
         res[k] = useBlk ? blk[k][idx] : randResidual();
      end
   endtask

   task automatic loadVector(input int v);
      for (int k = 0; k < NORD; k++) begin
         for (int i = 0; i < BS; i++) begin
            blk[k][i] = 16'((i < WARMUP) ? vectors[v].warm[k] : vectors[v].body[k]);
         end
      end
   endtask

   task automatic loadRandom();
      for (int k = 0; k < NORD; k++) begin
         for (int i = 0; i < BS; i++) begin
            blk[k][i] = randResidual();
         end
      end
   endtask

   // Present the first count samples of blk, start on index 0, with
   // optional idle cycles sprinkled in between
   task automatic feedSamples(input int count, input bit stalls);
      for (int i = 0; i < count; i++) begin
         if (stalls) begin
            for (int s = 0; s < 3; s++) begin
               if ($urandom_range(0, 2) == 0) begin
                  applyStimulus(1'b0, 1'b0, 1'b0, 0);
                  tick();
               end
            end
         end
         applyStimulus(1'b1, (i == 0), 1'b1, i);
         tick();
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 0);
   endtask

   // Full block: feed, then watch the result window after the last sample
   task automatic runBlock(input bit stalls, input bit garbage, input int expOrder,
                           input longint expSum, input string name);
      int validAt;
      int validCount;
      validAt    = 0;
      validCount = 0;
      stray      = 0;
      allowValid = 1'b0;
      feedSamples(BS, stalls);
      checkOutput({name, " early valid"}, stray, 0);
      allowValid = 1'b1;
      if (garbage) applyStimulus(1'b1, 1'b1, 1'b0, 0);
      for (int k = 1; k <= 8; k++) begin
         if (k == 7) applyStimulus(1'b0, 1'b0, 1'b0, 0);
         tick();
         if (oValid) begin
            validCount++;
            if (validAt == 0) validAt = k;
         end
         if (k <= 6) checkOutput($sformatf("%s busy@%0d", name, k), oBusy, (k < 5) ? 1 : 0);
         if (k == 6) begin
            checkOutput({name, " order"}, oBestOrder, expOrder);
            checkOutput({name, " sum"}, oBestSum, expSum);
         end
      end
      checkOutput({name, " valid edge"}, validAt, 6);
      checkOutput({name, " valid pulses"}, validCount, 1);
      checkOutput({name, " order held"}, oBestOrder, expOrder);
      allowValid = 1'b0;
   endtask

   initial begin
      int     mOrder;
      longint mSum;

      vectors[0].warm = '{100, 5, 0, 3, 7};
      vectors[0].body = '{100, 5, 0, 3, 7};
      vectors[0].expOrder = 2;
      vectors[0].expSum   = 0;
      vectors[1].warm = '{9, 2, 9, 2, 9};
      vectors[1].body = '{9, 2, 9, 2, 9};
      vectors[1].expOrder = 1;
      vectors[1].expSum   = 24;
      vectors[2].warm = '{-32768, 32767, 32767, 32767, 32767};
      vectors[2].body = '{-32768, 32767, 32767, 32767, 32767};
      vectors[2].expOrder = 1;
      vectors[2].expSum   = 393204;
      vectors[3].warm = '{1, 1, 1, 1, 1000};
      vectors[3].body = '{1, 1, 1, 1, 0};
      vectors[3].expOrder = 4;
      vectors[3].expSum   = 0;

      // Reset with start/enable asserted: reset must win
      iReset = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b0, 0);
      tick();
      tick();
      checkOutput("reset valid", oValid, 0);
      checkOutput("reset busy", oBusy, 0);
      checkOutput("reset order", oBestOrder, 0);
      checkOutput("reset sum", oBestSum, 0);
      iReset = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 0);
      tick();
      checkOutput("post reset busy", oBusy, 0);

      // Directed table
      for (int v = 0; v < 4; v++) begin
         loadVector(v);
         runBlock(v[0], 1'b0, vectors[v].expOrder, vectors[v].expSum, $sformatf("vec%0d", v));
      end

      // Random blocks with stalls, some with inputs thrown at COMPARE/DONE
      for (int n = 0; n < 6; n++) begin
         loadRandom();
         referenceModel(mOrder, mSum);
         runBlock(1'b1, n[0], mOrder, mSum, $sformatf("rand%0d", n));
      end

      // Restart mid-block: 8 junk samples then a fresh start
      stray = 0;
      for (int k = 0; k < NORD; k++) begin
         for (int i = 0; i < BS; i++) blk[k][i] = 16'sd30000;
      end
      feedSamples(8, 1'b0);
      tick();
      checkOutput("restart junk valid", stray, 0);
      loadRandom();
      referenceModel(mOrder, mSum);
      runBlock(1'b0, 1'b0, mOrder, mSum, "restart");

      // Leave nonzero results behind, then reset in the middle of COMPARE
      loadVector(2);
      runBlock(1'b0, 1'b0, vectors[2].expOrder, vectors[2].expSum, "pre-reset");
      loadRandom();
      stray = 0;
      feedSamples(BS, 1'b0);
      tick();
      tick();
      checkOutput("mid-compare busy", oBusy, 1);
      iReset = 1'b1;
      tick();
      iReset = 1'b0;
      checkOutput("compare reset order", oBestOrder, 0);
      checkOutput("compare reset sum", oBestSum, 0);
      checkOutput("compare reset valid", oValid, 0);
      checkOutput("compare reset busy", oBusy, 0);
      for (int i = 0; i < 10; i++) tick();
      checkOutput("compare reset no valid", stray, 0);
      checkOutput("compare reset idle", oBusy, 0);
      loadRandom();
      referenceModel(mOrder, mSum);
      runBlock(1'b1, 1'b0, mOrder, mSum, "after-reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
